// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU-core types: stack op codes, M-/T-cycle types, T indices.
//            STACK_SEQ_RETI_EN makes op 4 (RETI) a legal stack op.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_RST  = 3'd2,
    OP_RET  = 3'd3,
    OP_RETI = 3'd4
  } stack_op_t;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_M2   = 2'd1,
    MC_M3   = 2'd2,
    MC_M4   = 2'd3
  } mcyc_t;

  typedef logic [1:0] tcyc_t;

  localparam tcyc_t T1 = 2'd0;
  localparam tcyc_t T2 = 2'd1;
  localparam tcyc_t T3 = 2'd2;
  localparam tcyc_t T4 = 2'd3;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef STACK_SEQ_RETI_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/tcyc_counter.sv
// ============================================================================
// Module   : tcyc_counter
// Purpose  : T1..T4 state counter with run/clear and a T4 strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcyc_counter
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  run,
  input  logic  clr,
  output tcyc_t t,
  output logic  t4
);

  tcyc_t t_q;
  tcyc_t t_d;

  always_comb begin
    t_d = t_q;
    if (clr) begin
      t_d = T1;
    end else if (run) begin
      t_d = t_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q <= T1;
    end else begin
      t_q <= t_d;
    end
  end

  assign t  = t_q;
  assign t4 = run && (t_q == T4);

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
// ============================================================================
// Module   : stack_seq
// Purpose  : Stack micro-sequencer for PUSH/POP/RST/RET M-cycles after M1.
//            Define STACK_SEQ_RETI_EN to enable RETI (op 4) with ime_set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_seq
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] src_val,
  input  logic [2:0]  rst_vec,
  input  logic [15:0] sp_in,
  input  logic [7:0]  din,
  output logic        busy,
  output logic [15:0] adr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  dout,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic [15:0] res_val,
  output logic        res_we,
  output logic        res_pc,
  output logic        ime_set,
  output logic        done
);

  mcyc_t       state_q, state_d;
  stack_op_t   op_q, op_d;
  logic [15:0] src_q, src_d;
  logic [2:0]  vec_q, vec_d;
  logic [15:0] sp_q, sp_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;

  tcyc_t t;
  logic  t4;
  logic  push_like;
  logic  final_t4;
  logic  in_write;

  tcyc_counter u_tcyc (
    .clk (clk),
    .rst (rst),
    .run (busy),
    .clr (!busy),
    .t   (t),
    .t4  (t4)
  );

  assign busy      = (state_q != MC_IDLE);
  assign push_like = (op_q == OP_PUSH) || (op_q == OP_RST);
  assign final_t4  = t4 && (state_q == ((op_q == OP_POP) ? MC_M3 : MC_M4));
  assign in_write  = push_like && ((state_q == MC_M3) || (state_q == MC_M4));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    vec_d   = vec_q;
    sp_d    = sp_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    adr     = 16'h0000;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    dout    = 8'h00;
    sp_out  = 16'h0000;
    sp_we   = 1'b0;
    res_val = 16'h0000;
    res_we  = 1'b0;
    res_pc  = 1'b0;
    ime_set = 1'b0;
    done    = 1'b0;

    if (state_q == MC_IDLE) begin
      if (start && op_legal(op)) begin
        state_d = MC_M2;
        op_d    = stack_op_t'(op);
        src_d   = src_val;
        vec_d   = rst_vec;
      end
    end else begin
      // SP is live at T1 (consumer just wrote it back); held for T2..T4
      if (t == T1) begin
        sp_d = sp_in;
        adr  = sp_in;
      end else begin
        adr  = sp_q;
      end

      if (in_write) begin
        mem_wr = (t == T2) || (t == T3);
        if (t != T1) begin
          dout = (state_q == MC_M3) ? src_q[15:8] : src_q[7:0];
        end
      end

      if (!push_like && (state_q != MC_M4)) begin
        mem_rd = (t != T4);
        if (t == T3) begin
          if (state_q == MC_M2) begin
            lo_d = din;
          end else begin
            hi_d = din;
          end
        end
      end

      if (t4 && (state_q != MC_M4)) begin
        sp_we  = 1'b1;
        sp_out = push_like ? (sp_q - 16'd1) : (sp_q + 16'd1);
      end

      if (final_t4) begin
        done    = 1'b1;
        state_d = MC_IDLE;
        if (op_q != OP_PUSH) begin
          res_we  = 1'b1;
          res_pc  = (op_q != OP_POP);
          res_val = (op_q == OP_RST) ? {10'b0, vec_q, 3'b000} : {hi_q, lo_q};
        end
`ifdef STACK_SEQ_RETI_EN
        ime_set = (op_q == OP_RETI);
`else
        ime_set = 1'b0;
`endif
      end else if (t4) begin
        state_d = (state_q == MC_M2) ? MC_M3 : MC_M4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MC_IDLE;
      op_q    <= OP_PUSH;
      src_q   <= 16'h0000;
      vec_q   <= 3'd0;
      sp_q    <= 16'h0000;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      vec_q   <= vec_d;
      sp_q    <= sp_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stack_seq.sv
// ============================================================================
// Module   : tb_stack_seq
// Purpose  : Self-checking bench for stack_seq against an M-cycle list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stack_seq;

  localparam int K_INT = 0;
  localparam int K_RD  = 1;
  localparam int K_WR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] src_val;
  logic [2:0]  rst_vec;
  logic [15:0] sp_in;
  logic [7:0]  din;
  logic        busy;
  logic [15:0] adr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  dout;
  logic [15:0] sp_out;
  logic        sp_we;
  logic [15:0] res_val;
  logic        res_we;
  logic        res_pc;
  logic        ime_set;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  stack_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_val (src_val),
    .rst_vec (rst_vec),
    .sp_in   (sp_in),
    .din     (din),
    .busy    (busy),
    .adr     (adr),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .dout    (dout),
    .sp_out  (sp_out),
    .sp_we   (sp_we),
    .res_val (res_val),
    .res_we  (res_we),
    .res_pc  (res_pc),
    .ime_set (ime_set),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"},    busy,    16'd0);
    chk({tag, " adr"},     adr,     16'd0);
    chk({tag, " mem_rd"},  mem_rd,  16'd0);
    chk({tag, " mem_wr"},  mem_wr,  16'd0);
    chk({tag, " dout"},    dout,    16'd0);
    chk({tag, " sp_we"},   sp_we,   16'd0);
    chk({tag, " sp_out"},  sp_out,  16'd0);
    chk({tag, " res_we"},  res_we,  16'd0);
    chk({tag, " res_val"}, res_val, 16'd0);
    chk({tag, " res_pc"},  res_pc,  16'd0);
    chk({tag, " ime_set"}, ime_set, 16'd0);
    chk({tag, " done"},    done,    16'd0);
  endtask

  // Model: each op is a list of M-cycles (kind, SP delta, data byte).
  // The bench plays the SP consumer, presenting the model's SP at each T1.
  task automatic run_op(input string name, input int opv, input logic [15:0] src,
                        input logic [2:0] vec, input logic [15:0] sp0,
                        input logic [7:0] lo, input logic [7:0] hi,
                        input int abort_at, input bit noise,
                        output logic [15:0] sp_end);
    int          kind[3];
    int          dlt[3];
    logic [7:0]  dat[3];
    int          nm;
    logic [15:0] sp;
    sp = sp0;
    if (opv == 0 || opv == 2) begin
      nm = 3;
      kind[0] = K_INT; dlt[0] = -1; dat[0] = 8'h00;
      kind[1] = K_WR;  dlt[1] = -1; dat[1] = src[15:8];
      kind[2] = K_WR;  dlt[2] = 0;  dat[2] = src[7:0];
    end else begin
      nm = (opv == 1) ? 2 : 3;
      kind[0] = K_RD;  dlt[0] = 1;  dat[0] = lo;
      kind[1] = K_RD;  dlt[1] = 1;  dat[1] = hi;
      kind[2] = K_INT; dlt[2] = 0;  dat[2] = 8'h00;
    end

    start = 1'b1; op = 3'(opv); src_val = src; rst_vec = vec; sp_in = sp0;
    tick;
    start = 1'b0;
    src_val = 16'($urandom);
    rst_vec = 3'($urandom);

    for (int k = 1; k <= nm * 4; k++) begin
      int     m;
      int     t;
      bit     last;
      bit     e_spwe;
      bit     e_res;
      string  tg;
      m    = (k - 1) / 4;
      t    = (k - 1) % 4;
      last = (k == nm * 4);
      tg   = $sformatf("%s c%0d", name, k);
      sp_in = sp;
      din   = (kind[m] == K_RD && t == 2) ? dat[m] : 8'($urandom);
      if (noise) begin
        start = ($urandom_range(0, 2) == 0);
        op    = 3'($urandom);
      end
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk_quiet({tg, " in-reset"});
        tick;
        chk_quiet({tg, " after-reset"});
        chk({tg, " no res_we"}, res_we, 16'd0);
        rst   = 1'b0;
        start = 1'b0;
        sp_end = sp;
        return;
      end
      #1;
      e_spwe = (t == 3) && (dlt[m] != 0);
      e_res  = last && (opv != 0);
      chk({tg, " busy"},   busy,   16'd1);
      chk({tg, " adr"},    adr,    sp);
      chk({tg, " mem_rd"}, mem_rd, 16'(kind[m] == K_RD && t != 3));
      chk({tg, " mem_wr"}, mem_wr, 16'(kind[m] == K_WR && (t == 1 || t == 2)));
      if (kind[m] != K_WR) begin
        chk({tg, " dout idle"}, dout, 16'd0);
      end else if (t != 0) begin
        chk({tg, " dout"}, dout, {8'h00, dat[m]});
      end
      chk({tg, " sp_we"}, sp_we, 16'(e_spwe));
      if (e_spwe) begin
        chk({tg, " sp_out"}, sp_out, 16'(32'(sp) + dlt[m]));
      end
      chk({tg, " res_we"}, res_we, 16'(e_res));
      if (e_res) begin
        chk({tg, " res_val"}, res_val, (opv == 2) ? {10'b0, vec, 3'b000} : {hi, lo});
        chk({tg, " res_pc"},  res_pc,  16'(opv != 1));
      end
      chk({tg, " done"},    done,    16'(last));
      chk({tg, " ime_set"}, ime_set, 16'(last && opv == 4));
      if (t == 3) sp = 16'(32'(sp) + dlt[m]);
      if (!last) begin
        @(posedge clk);
        #0;
      end
      // Final cycle: a start coincident with done must be ignored.
      if (last && noise) begin
        start = 1'b1;
        op    = 3'($urandom_range(0, 3));
      end
      if (!last) #0;
      if (!last) #1;
      if (!last) #(-0);
    end
    tick;
    start = 1'b0;
    chk({name, " post busy"}, busy, 16'd0);
    chk({name, " post done"}, done, 16'd0);
    chk({name, " post adr"},  adr,  16'd0);
    sp_end = sp;
  endtask

  task automatic try_illegal(input string name, input int opv);
    start = 1'b1; op = 3'(opv);
    tick;
    start = 1'b0;
    chk({name, " busy c1"}, busy, 16'd0);
    tick;
    chk({name, " busy c2"}, busy, 16'd0);
  endtask

  initial begin
    logic [15:0] spe;
    int          opv;
    int          nops;
    logic [15:0] sp0;
    rst = 1'b1; start = 1'b0; op = 3'd0; src_val = 16'h0;
    rst_vec = 3'd0; sp_in = 16'h0; din = 8'h0;
    tick;
    tick;
    chk_quiet("reset");
    rst = 1'b0;
    tick;
    chk_quiet("idle");

    run_op("push", 0, 16'h1234, 3'd0, 16'hFFFE, 8'h00, 8'h00, 0, 1'b0, spe);
    chk("push final sp", spe, 16'hFFFC);
    run_op("pop", 1, 16'h0000, 3'd0, 16'hFFFC, 8'h34, 8'h12, 0, 1'b0, spe);
    chk("pop final sp", spe, 16'hFFFE);
    run_op("push wrap", 0, 16'hA55A, 3'd0, 16'h0001, 8'h00, 8'h00, 0, 1'b0, spe);
    chk("push wrap final sp", spe, 16'hFFFF);
    run_op("pop wrap", 1, 16'h0000, 3'd0, 16'hFFFF, 8'hC3, 8'h3C, 0, 1'b0, spe);
    chk("pop wrap final sp", spe, 16'h0001);
    run_op("rst", 2, 16'h0150, 3'd7, 16'hD000, 8'h00, 8'h00, 0, 1'b0, spe);
    run_op("ret", 3, 16'h0000, 3'd0, 16'hCFFE, 8'h50, 8'h01, 0, 1'b0, spe);
    run_op("ret abort", 3, 16'h0000, 3'd0, 16'h8000, 8'h11, 8'h22, 6, 1'b0, spe);
    run_op("push after abort", 0, 16'hBEEF, 3'd0, 16'h4000, 8'h00, 8'h00, 0, 1'b0, spe);

`ifdef STACK_SEQ_RETI_EN
    run_op("reti", 4, 16'h0000, 3'd0, 16'h1000, 8'h78, 8'h56, 0, 1'b0, spe);
`else
    try_illegal("op4 illegal", 4);
`endif
    try_illegal("op5 illegal", 5);
    try_illegal("op6 illegal", 6);
    try_illegal("op7 illegal", 7);

`ifdef STACK_SEQ_RETI_EN
    nops = 5;
`else
    nops = 4;
`endif
    for (int i = 0; i < 30; i++) begin
      opv = $urandom_range(0, nops - 1);
      case ($urandom_range(0, 3))
        0:       sp0 = 16'($urandom_range(0, 2));
        1:       sp0 = 16'hFFFF - 16'($urandom_range(0, 2));
        default: sp0 = 16'($urandom);
      endcase
      run_op($sformatf("rnd%0d op%0d", i, opv), opv, 16'($urandom), 3'($urandom), sp0,
             8'($urandom), 8'($urandom), 0, 1'b1, spe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
